// File: rtl/hdmi_packet_assembler.sv
// HDMI data-island packet assembler: serialises a 24-bit header and four 56-bit
// subpackets into 9-bit TERC4 pixels and inserts BCH parity as the bits go out.
module hdmi_packet_assembler (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        data_island_period,
    input  logic [23:0] header,
    input  logic [55:0] sub [3:0],
    output logic [8:0]  packet_data,
    output logic [4:0]  counter,
    output logic        packet_end
);

    // One LSB-first step of the BCH LFSR with generator 0x83.
    function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic bit_in);
        bch_step = (ecc >> 1) ^ (((ecc[0] ^ bit_in) == 1'b1) ? 8'h83 : 8'h00);
    endfunction

    logic [4:0] counter_r;
    logic [7:0] ecc_h_r;
    logic [7:0] ecc_s_r      [3:0];
    logic [7:0] ecc_h_next_s;
    logic [7:0] ecc_s_next_s [3:0];
    logic       hdr_bit_s;
    logic [3:0] b0_s;
    logic [3:0] b1_s;

    // Select data or parity bits for the current index and advance the LFSRs.
    always_comb begin
        hdr_bit_s    = 1'b0;
        b0_s         = 4'b0000;
        b1_s         = 4'b0000;
        ecc_h_next_s = ecc_h_r;
        for (int i = 0; i < 4; i++) begin
            ecc_s_next_s[i] = ecc_s_r[i];
        end

        if (counter_r < 5'd24) begin
            hdr_bit_s    = header[counter_r];
            ecc_h_next_s = bch_step(ecc_h_r, header[counter_r]);
        end else begin
            // Indices 24..31 map onto parity bits 0..7 via the low three bits.
            hdr_bit_s    = ecc_h_r[counter_r[2:0]];
            ecc_h_next_s = ecc_h_r;
        end

        for (int i = 0; i < 4; i++) begin
            if (counter_r < 5'd28) begin
                b0_s[i]         = sub[i][{counter_r, 1'b0}];
                b1_s[i]         = sub[i][{counter_r, 1'b1}];
                ecc_s_next_s[i] = bch_step(bch_step(ecc_s_r[i], sub[i][{counter_r, 1'b0}]),
                                           sub[i][{counter_r, 1'b1}]);
            end else begin
                b0_s[i]         = ecc_s_r[i][{counter_r[1:0], 1'b0}];
                b1_s[i]         = ecc_s_r[i][{counter_r[1:0], 1'b1}];
                ecc_s_next_s[i] = ecc_s_r[i];
            end
        end
    end

    // Packet position and parity state; island low or packet wrap starts clean.
    always_ff @(posedge clk_pixel) begin
        if (reset || !data_island_period || (counter_r == 5'd31)) begin
            counter_r <= 5'd0;
            ecc_h_r   <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                ecc_s_r[i] <= 8'h00;
            end
        end else begin
            counter_r <= counter_r + 5'd1;
            ecc_h_r   <= ecc_h_next_s;
            for (int i = 0; i < 4; i++) begin
                ecc_s_r[i] <= ecc_s_next_s[i];
            end
        end
    end

    assign packet_data = {b1_s, b0_s, hdr_bit_s};
    assign counter     = counter_r;
    assign packet_end  = data_island_period && (counter_r == 5'd31);

endmodule

// File: tb/tb_hdmi_packet_assembler.sv
// Scoreboard bench for hdmi_packet_assembler: expected pixels come from whole-codeword
// BCH model built per packet; a negedge monitor pops and compares.
module tb_hdmi_packet_assembler;

    logic        clk_pixel;
    logic        reset;
    logic        data_island_period;
    logic [23:0] header_t;
    logic [55:0] sub_t [3:0];
    logic [8:0]  packet_data;
    logic [4:0]  counter;
    logic        packet_end;

    typedef struct {
        logic [8:0] data;
        logic [4:0] cnt;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    logic mon_en;
    logic final_chk;

    hdmi_packet_assembler dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .header             (header_t),
        .sub                (sub_t),
        .packet_data        (packet_data),
        .counter            (counter),
        .packet_end         (packet_end)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // Parity of the first n bits of a message, fed LSB first through the BCH step.
    function automatic logic [7:0] model_par(input logic [63:0] bits, input int n);
        logic [7:0] ecc;
        ecc = 8'h00;
        for (int k = 0; k < n; k++) begin
            ecc = (ecc >> 1) ^ (((ecc[0] ^ bits[k]) == 1'b1) ? 8'h83 : 8'h00);
        end
        return ecc;
    endfunction

    // Pixel c of the current packet, read out of the full 32/64-bit codewords.
    function automatic logic [8:0] model_pixel(input int c);
        logic [31:0] hcw;
        logic [63:0] scw;
        logic [3:0]  b0;
        logic [3:0]  b1;
        hcw = {model_par({40'h0, header_t}, 24), header_t};
        for (int i = 0; i < 4; i++) begin
            scw   = {model_par({8'h00, sub_t[i]}, 56), sub_t[i]};
            b0[i] = scw[2 * c];
            b1[i] = scw[2 * c + 1];
        end
        return {b1, b0, hcw[c]};
    endfunction

    task automatic push_exp(input int c, input logic pend);
        exp_t e;
        e.data = model_pixel(c);
        e.cnt  = 5'(c);
        e.pend = pend;
        exp_q.push_back(e);
    endtask

    // Runs n island cycles of the current packet from counter 0, expectations queued first.
    task automatic run_packet(input int n);
        for (int c = 0; c < n; c++) begin
            push_exp(c, (c == 31) ? 1'b1 : 1'b0);
        end
        data_island_period = 1'b1;
        mon_en             = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    task automatic random_inputs();
        header_t = 24'($urandom);
        for (int i = 0; i < 4; i++) begin
            sub_t[i] = {24'($urandom), 32'($urandom)};
        end
    endtask

    task automatic end_island();
        data_island_period = 1'b0;
        mon_en             = 1'b0;
        repeat (2) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    // Monitor: the only process that compares and counts.
    always @(negedge clk_pixel) begin
        exp_t e;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got output at counter %0d, required a queued expectation", counter);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (packet_data !== e.data) begin
                    errors++;
                    $display("FAIL packet_data @cnt %0d: got %03h required %03h", e.cnt, packet_data, e.data);
                end
                checks++;
                if (counter !== e.cnt) begin
                    errors++;
                    $display("FAIL counter: got %0d required %0d", counter, e.cnt);
                end
                checks++;
                if (packet_end !== e.pend) begin
                    errors++;
                    $display("FAIL packet_end @cnt %0d: got %0b required %0b", e.cnt, packet_end, e.pend);
                end
            end
        end
        if (final_chk) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL sb_leftover: got %0d entries left, required 0", exp_q.size());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit reached, required run end");
        $fatal(1, "watchdog");
    end

    initial begin
        checks             = 0;
        errors             = 0;
        mon_en             = 1'b0;
        final_chk          = 1'b0;
        reset              = 1'b1;
        data_island_period = 1'b0;
        random_inputs();
        repeat (2) @(posedge clk_pixel);
        #1;

        // Reset state: counter 0, no packet_end, pixel 0 of the live inputs.
        push_exp(0, 1'b0);
        mon_en = 1'b1;
        @(posedge clk_pixel);
        #1;
        mon_en = 1'b0;
        reset  = 1'b0;
        @(posedge clk_pixel);
        #1;

        // All-zero packet, then header bit 0 only, then sub[2] bit 0 only, back to back.
        header_t = 24'h000000;
        for (int i = 0; i < 4; i++) sub_t[i] = 56'h0;
        run_packet(32);
        header_t = 24'h000001;
        run_packet(32);
        header_t = 24'h000000;
        sub_t[2] = 56'h1;
        run_packet(32);

        // Two random packets back to back.
        random_inputs();
        run_packet(32);
        random_inputs();
        run_packet(32);
        end_island();

        // Abort at counter 13, then a fresh packet.
        random_inputs();
        run_packet(13);
        end_island();
        random_inputs();
        run_packet(32);
        end_island();

        // Reset at counter 20 with the island still high.
        random_inputs();
        run_packet(20);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk_pixel);
        #1;
        reset = 1'b0;
        run_packet(32);
        end_island();

        // Longer random back-to-back run.
        for (int p = 0; p < 8; p++) begin
            random_inputs();
            run_packet(32);
        end
        end_island();

        final_chk = 1'b1;
        @(negedge clk_pixel);
        #1;
        final_chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
